// File: rtl/hazard_pkg.sv
// Shared decode constants and enums for the ID-stage hazard unit.
// Func codes cover the SPECIAL/SPECIAL2 multi-cycle ops.
package hazard_pkg;

  localparam logic [5:0] MUL  = 6'b000010;
  localparam logic [5:0] CLZ  = 6'b100000;
  localparam logic [5:0] CLO  = 6'b100001;
  localparam logic [5:0] DIV  = 6'b011010;
  localparam logic [5:0] DIVU = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } hdu_state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'b00,
    C_LU   = 2'b01,
    C_MUL  = 2'b10,
    C_DIV  = 2'b11
  } stall_cause_t;

endpackage

// File: rtl/mc_hazard_unit_stall_counter.sv
// Saturating event counter used to track stall cycles.
// Holds at all-ones; cleared only by reset.
module stall_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mc_hazard_unit.sv
// ID-stage hazard unit: load-use stalls plus multi-cycle
// mul/div stall sequencing and a stall-cycle counter.
module mc_hazard_unit
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             MULOp,
  input  logic             ALUOp,
  input  logic [5:0]       Func,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rt,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic [1:0]       StallCause,
  output logic [CNT_W-1:0] StallCount
);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 1);

  hdu_state_t   state_q, state_d;
  stall_cause_t cause_q, cause_d, cause_o;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         stall_o;
  logic         mul_issue, div_issue, lu_haz;

  assign mul_issue = MULOp &
    ((Func == MUL) | (Func == CLO) | (Func == CLZ));
  assign div_issue = ALUOp &
    ((Func == DIV) | (Func == DIVU));
  assign lu_haz = EX_MemRead & (EX_Rt != '0) &
    ((EX_Rt == ID_Rs) | (EX_Rt == ID_Rt));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    stall_o = 1'b0;
    cause_o = C_NONE;
    if (Flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      cause_d = C_NONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // issues are masked while reset is held
          if (lu_haz) begin
            stall_o = 1'b1;
            cause_o = C_LU;
          end else if (mul_issue && nReset) begin
            stall_o = 1'b1;
            cause_o = C_MUL;
            cause_d = C_MUL;
            if (MUL_LAT == 1) begin
              state_d = S_RELEASE;
            end else begin
              cnt_d   = MUL_LD;
              state_d = S_BUSY;
            end
          end else if (div_issue && nReset) begin
            stall_o = 1'b1;
            cause_o = C_DIV;
            cause_d = C_DIV;
            if (DIV_LAT == 1) begin
              state_d = S_RELEASE;
            end else begin
              cnt_d   = DIV_LD;
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          stall_o = 1'b1;
          cause_o = cause_q;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: begin
          state_d = S_IDLE;
          if (lu_haz) begin
            stall_o = 1'b1;
            cause_o = C_LU;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= C_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  stall_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (Clock),
    .rst_n (nReset),
    .en    (stall_o),
    .count (StallCount)
  );

  assign Stall      = stall_o;
  assign StallCause = cause_o;
  assign Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mc_hazard_unit.sv
// Bench for mc_hazard_unit: two instances (default and short
// latency / 4-bit counter) against a remaining-cycles model.
module tb_mc_hazard_unit;
  import hazard_pkg::*;

  logic       Clock = 1'b0;
  logic       nReset = 1'b1;
  logic       MULOp = 1'b0;
  logic       ALUOp = 1'b0;
  logic       EX_MemRead = 1'b0;
  logic       Flush = 1'b0;
  logic [5:0] Func = 6'd0;
  logic [4:0] ID_Rs = 5'd0;
  logic [4:0] ID_Rt = 5'd0;
  logic [4:0] EX_Rt = 5'd0;

  logic        st1, bz1, st2, bz2;
  logic [1:0]  cs1, cs2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  mc_hazard_unit dut1 (
    .Clock      (Clock),
    .nReset     (nReset),
    .MULOp      (MULOp),
    .ALUOp      (ALUOp),
    .Func       (Func),
    .ID_Rs      (ID_Rs),
    .ID_Rt      (ID_Rt),
    .EX_MemRead (EX_MemRead),
    .EX_Rt      (EX_Rt),
    .Flush      (Flush),
    .Stall      (st1),
    .Busy       (bz1),
    .StallCause (cs1),
    .StallCount (cnt1)
  );

  mc_hazard_unit #(
    .MUL_LAT (1),
    .DIV_LAT (3),
    .REG_W   (5),
    .CNT_W   (4)
  ) dut2 (
    .Clock      (Clock),
    .nReset     (nReset),
    .MULOp      (MULOp),
    .ALUOp      (ALUOp),
    .Func       (Func),
    .ID_Rs      (ID_Rs),
    .ID_Rt      (ID_Rt),
    .EX_MemRead (EX_MemRead),
    .EX_Rt      (EX_Rt),
    .Flush      (Flush),
    .Stall      (st2),
    .Busy       (bz2),
    .StallCause (cs2),
    .StallCount (cnt2)
  );

  logic [19:0] obs [2];
  always_comb begin
    obs[0] = {st1, cs1, bz1, cnt1};
    obs[1] = {st2, cs2, bz2, 12'd0, cnt2};
  end

  // model: remaining stall cycles after the issue cycle,
  // a pending one-cycle release, held cause, stall total
  int mlat [2] = '{4, 1};
  int dlat [2] = '{32, 3};
  int cmax [2] = '{65535, 15};
  int m_rem [2];
  int m_rel [2];
  int m_cause [2];
  int m_cnt [2];

  function automatic bit lu();
    return EX_MemRead && (EX_Rt != 0) &&
      ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));
  endfunction

  function automatic bit mi();
    return MULOp &&
      ((Func == MUL) || (Func == CLO) || (Func == CLZ));
  endfunction

  function automatic bit di();
    return ALUOp && ((Func == DIV) || (Func == DIVU));
  endfunction

  function automatic logic [19:0] expv(int k);
    bit st;
    int cs;
    bit bz;
    st = 0;
    cs = 0;
    bz = (m_rem[k] > 0) || (m_rel[k] != 0);
    if (!Flush) begin
      if (m_rem[k] > 0) begin
        st = 1; cs = m_cause[k];
      end else if (lu()) begin
        st = 1; cs = 1;
      end else if (m_rel[k] == 0 && nReset) begin
        if (mi()) begin
          st = 1; cs = 2;
        end else if (di()) begin
          st = 1; cs = 3;
        end
      end
    end
    return {st, 2'(cs), bz, 16'(m_cnt[k])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0;
      m_rel[k] = 0;
      m_cause[k] = 0;
      m_cnt[k] = 0;
    end
  endtask

  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      logic [19:0] e;
      e = expv(k);
      if (nReset) begin
        if (e[19] && m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (Flush) begin
          m_rem[k] = 0;
          m_rel[k] = 0;
        end else if (m_rem[k] > 0) begin
          m_rem[k]--;
          if (m_rem[k] == 0) m_rel[k] = 1;
        end else if (m_rel[k] != 0) begin
          m_rel[k] = 0;
        end else if (!lu() && mi()) begin
          m_cause[k] = 2;
          m_rem[k] = mlat[k] - 1;
          m_rel[k] = (m_rem[k] == 0) ? 1 : 0;
        end else if (!lu() && di()) begin
          m_cause[k] = 3;
          m_rem[k] = dlat[k] - 1;
          m_rel[k] = (m_rem[k] == 0) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge Clock);
    commit();
    #1;
  endtask

  task automatic clear_inputs();
    MULOp = 0; ALUOp = 0; EX_MemRead = 0; Flush = 0;
    Func = 6'd0; ID_Rs = 0; ID_Rt = 0; EX_Rt = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    nReset = 0;
    model_reset();
    @(posedge Clock);
    #1;
    nReset = 1;
  endtask

  task automatic test_reset();
    #1;
    nReset = 0;
    model_reset();
    #1;
    checks++;
    if (obs[0] !== 20'h0) begin
      errors++;
      $display("FAIL reset_vals got=%h exp=%h", obs[0], 20'h0);
    end
    EX_MemRead = 1; EX_Rt = 5; ID_Rs = 5;
    MULOp = 1; Func = MUL;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== expv(k)) begin
        errors++;
        $display("FAIL reset_lu dut%0d got=%h exp=%h",
          k, obs[k], expv(k));
      end
    end
    @(posedge Clock);
    #1;
    clear_inputs();
    nReset = 1;
    ALUOp = 1; Func = DIV;
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL reset_div c%0d dut%0d got=%h exp=%h",
            c, k, obs[k], expv(k));
        end
      end
      step();
    end
    ALUOp = 0;
    #2;
    nReset = 0;
    model_reset();
    #1;
    checks++;
    if (obs[0] !== 20'h0) begin
      errors++;
      $display("FAIL reset_midbusy got=%h exp=%h", obs[0], 20'h0);
    end
    @(posedge Clock);
    #1;
    nReset = 1;
  endtask

  task automatic test_mul();
    int n;
    reset_dut();
    MULOp = 1; Func = MUL;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) MULOp = 0;
      #1;
      if (st1) n++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL mul c%0d dut%0d got=%h exp=%h",
            c, k, obs[k], expv(k));
        end
      end
      step();
    end
    checks++;
    if (n !== 4 || cnt1 !== 16'd4) begin
      errors++;
      $display("FAIL mul_total got=%0d/%0d exp=4/4", n, cnt1);
    end
  endtask

  task automatic test_div();
    int ns, nb;
    reset_dut();
    ALUOp = 1; Func = DIVU;
    ns = 0; nb = 0;
    for (int c = 0; c < 34; c++) begin
      if (c == 33) ALUOp = 0;
      #1;
      if (st1) ns++;
      if (bz1) nb++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL divu c%0d dut%0d got=%h exp=%h",
            c, k, obs[k], expv(k));
        end
      end
      step();
    end
    checks++;
    if (ns !== 32 || nb !== 32) begin
      errors++;
      $display("FAIL divu_len got=%0d/%0d exp=32/32", ns, nb);
    end
  endtask

  task automatic test_load_use();
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      unique case (c)
        0: begin EX_MemRead = 1; EX_Rt = 5; ID_Rs = 5; end
        2: begin EX_MemRead = 1; EX_Rt = 0; end
        3: begin EX_MemRead = 1; EX_Rt = 7; ID_Rt = 7; end
        default: ;
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL lu c%0d dut%0d got=%h exp=%h",
            c, k, obs[k], expv(k));
        end
      end
      step();
    end
    checks++;
    if (cnt1 !== 16'd2) begin
      errors++;
      $display("FAIL lu_total got=%0d exp=2", cnt1);
    end
  endtask

  task automatic test_lu_mul();
    reset_dut();
    MULOp = 1; Func = MUL;
    for (int c = 0; c < 7; c++) begin
      EX_MemRead = (c == 0);
      EX_Rt = 9; ID_Rs = 9;
      if (c == 6) MULOp = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL lu_mul c%0d dut%0d got=%h exp=%h",
            c, k, obs[k], expv(k));
        end
      end
      step();
    end
    checks++;
    if (cnt1 !== 16'd5) begin
      errors++;
      $display("FAIL lu_mul_total got=%0d exp=5", cnt1);
    end
  endtask

  task automatic test_flush();
    reset_dut();
    ALUOp = 1; Func = DIV;
    for (int c = 0; c < 6; c++) begin
      Flush = (c == 3);
      if (c == 4) ALUOp = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL flush c%0d dut%0d got=%h exp=%h",
            c, k, obs[k], expv(k));
        end
      end
      if (c == 4) begin
        checks++;
        if (bz1 !== 1'b0 || st1 !== 1'b0) begin
          errors++;
          $display("FAIL flush_idle got=%b%b exp=00", bz1, st1);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    MULOp = 1; Func = CLO;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) Func = CLZ;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL b2b c%0d dut%0d got=%h exp=%h",
            c, k, obs[k], expv(k));
        end
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (st1 !== (c == 5)) begin
          errors++;
          $display("FAIL b2b_gap c%0d got=%b exp=%b",
            c, st1, (c == 5));
        end
      end
      step();
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    for (int c = 0; c < 21; c++) begin
      EX_MemRead = (c < 20);
      EX_Rt = 3; ID_Rs = 3;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL sat c%0d dut%0d got=%h exp=%h",
            c, k, obs[k], expv(k));
        end
      end
      step();
    end
    checks++;
    if (cnt2 !== 4'd15 || cnt1 !== 16'd20) begin
      errors++;
      $display("FAIL sat_total got=%0d/%0d exp=15/20", cnt2, cnt1);
    end
  endtask

  task automatic test_random();
    logic [5:0] funcs [6];
    funcs = '{MUL, CLZ, CLO, DIV, DIVU, 6'b100010};
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      MULOp = ($urandom_range(0, 9) < 4);
      ALUOp = ($urandom_range(0, 9) < 4);
      Func = funcs[$urandom_range(0, 5)];
      EX_MemRead = ($urandom_range(0, 3) == 0);
      EX_Rt = 5'($urandom_range(0, 3));
      ID_Rs = 5'($urandom_range(0, 3));
      ID_Rt = 5'($urandom_range(0, 3));
      Flush = ($urandom_range(0, 29) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          errors++;
          $display("FAIL rand c%0d dut%0d got=%h exp=%h",
            c, k, obs[k], expv(k));
        end
      end
      step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mul();
    test_div();
    test_load_use();
    test_lu_mul();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
